// File: rtl/sat_counter_table.sv
// Saturating-counter pattern table with on-chip init sweep,
// internal read-modify-write update pipeline and update-to-read bypass.
module sat_counter_table #(
   parameter int          ADDR_WIDTH = 8,
   parameter int          CTR_WIDTH  = 2,
   parameter int unsigned INIT_VALUE = (1 << (CTR_WIDTH - 1)) - 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  init_done,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rd_valid,
   output logic [CTR_WIDTH-1:0]  rd_data,
   output logic                  rd_pred,
   input  logic                  upd_en,
   input  logic [ADDR_WIDTH-1:0] upd_addr,
   input  logic                  upd_taken
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
   localparam logic [CTR_WIDTH-1:0] CTR_MIN  = '0;
   localparam logic [CTR_WIDTH-1:0] CTR_ONE  = CTR_WIDTH'(1);
   localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'(INIT_VALUE);

   typedef enum logic {
      INIT,
      READY
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] idx;

   logic [CTR_WIDTH-1:0]  mem [DEPTH];

   logic                  s2_valid;
   logic [ADDR_WIDTH-1:0] s2_addr;
   logic                  s2_taken;

   logic [CTR_WIDTH-1:0]  s2_old;
   logic [CTR_WIDTH-1:0]  s2_new;
   logic                  ready;
   logic                  bypass_hit;

   assign ready = (state == READY);

   // Sweep FSM: one entry per cycle, READY after the last index is written.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= INIT;
         idx       <= '0;
         init_done <= 1'b0;
      end else begin
         unique case (state)
            INIT: begin
               idx <= idx + 1'b1;
               if (idx == '1) begin
                  state     <= READY;
                  init_done <= 1'b1;
               end
            end
            READY: begin
               state <= READY;
            end
         endcase
      end
   end

   // Stage 1: capture the update request.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
      end else begin
         s2_valid <= upd_en && ready;
         if (upd_en && ready) begin
            s2_addr  <= upd_addr;
            s2_taken <= upd_taken;
         end
      end
   end

   // Stage 2: saturating increment / decrement of the current entry.
   always_comb begin
      s2_old = mem[s2_addr];
      s2_new = s2_old;
      if (s2_taken) begin
         if (s2_old != CTR_MAX) begin
            s2_new = s2_old + CTR_ONE;
         end
      end else begin
         if (s2_old != CTR_MIN) begin
            s2_new = s2_old - CTR_ONE;
         end
      end
   end

   // Array is never reset; reset only blocks a pending stage-2 write.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (state == INIT) begin
            mem[idx] <= CTR_INIT;
         end else if (s2_valid) begin
            mem[s2_addr] <= s2_new;
         end
      end
   end

   assign bypass_hit = s2_valid && (s2_addr == rd_addr);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= rd_en && ready;
         if (rd_en && ready) begin
            rd_data <= bypass_hit ? s2_new : mem[rd_addr];
         end
      end
   end

   assign rd_pred = rd_data[CTR_WIDTH-1];

endmodule

// File: tb/tb_sat_counter_table.sv
// Directed bench for sat_counter_table (ADDR_WIDTH=8, CTR_WIDTH=2).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_sat_counter_table;

   logic       clk;
   logic       rst_n;
   logic       init_done;
   logic       rd_en;
   logic [7:0] rd_addr;
   logic       rd_valid;
   logic [1:0] rd_data;
   logic       rd_pred;
   logic       upd_en;
   logic [7:0] upd_addr;
   logic       upd_taken;

   int n_cmp;
   int n_err;

   sat_counter_table #(
      .ADDR_WIDTH(8),
      .CTR_WIDTH (2)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .init_done(init_done),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_valid (rd_valid),
      .rd_data  (rd_data),
      .rd_pred  (rd_pred),
      .upd_en   (upd_en),
      .upd_addr (upd_addr),
      .upd_taken(upd_taken)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Counts edges until init_done rises, bounded.
   task automatic wait_init(output int edges);
      edges = 0;
      while (!init_done && edges < 400) begin
         step();
         edges++;
      end
   endtask

   task automatic upd(input logic [7:0] a, input logic t);
      upd_en    = 1'b1;
      upd_addr  = a;
      upd_taken = t;
      step();
      upd_en    = 1'b0;
   endtask

   // Single read issued now, checked one cycle later as {valid,pred,data}.
   task automatic rd_chk(input string tag,
                         input logic [7:0] a,
                         input logic [1:0] exp);
      rd_en   = 1'b1;
      rd_addr = a;
      step();
      rd_en   = 1'b0;
      chk(tag, {rd_valid, rd_pred, rd_data}, {1'b1, exp[1], exp});
   endtask

   initial begin
      int edges;
      bit bad;
      logic [1:0] up_exp [4];
      logic [1:0] dn_exp [4];
      logic [1:0] col_exp [6];

      up_exp  = '{2'd2, 2'd3, 2'd3, 2'd3};
      dn_exp  = '{2'd0, 2'd0, 2'd0, 2'd1};
      col_exp = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

      n_cmp     = 0;
      n_err     = 0;
      rst_n     = 1'b0;
      rd_en     = 1'b0;
      rd_addr   = '0;
      upd_en    = 1'b0;
      upd_addr  = '0;
      upd_taken = 1'b0;

      step();
      step();
      chk("reset_init_done", init_done, 0);
      chk("reset_rd_valid", rd_valid, 0);
      chk("reset_rd_data", rd_data, 0);

      // Sweep with requests held high: they must be dropped.
      rd_en     = 1'b1;
      rd_addr   = 8'h20;
      upd_en    = 1'b1;
      upd_addr  = 8'h20;
      upd_taken = 1'b1;
      rst_n     = 1'b1;
      bad       = 1'b0;
      edges     = 0;
      while (!init_done && edges < 400) begin
         step();
         edges++;
         if (rd_valid) bad = 1'b1;
      end
      rd_en  = 1'b0;
      upd_en = 1'b0;
      chk("sweep_length", edges, 256);
      chk("init_rd_valid_quiet", bad, 0);

      // Every entry reads INIT_VALUE, pipelined one read per cycle.
      bad = 1'b0;
      for (int i = 0; i < 256; i++) begin
         rd_en   = 1'b1;
         rd_addr = 8'(i);
         step();
         if ({rd_valid, rd_pred, rd_data} !== 4'b1001) bad = 1'b1;
      end
      rd_en = 1'b0;
      chk("all_entries_init", bad, 0);
      step();
      chk("idle_rd_valid", rd_valid, 0);
      chk("idle_rd_data_hold", rd_data, 1);

      rd_chk("init_upd_dropped", 8'h20, 2'd1);

      // Upper saturation, each read bypasses the just-written value.
      for (int k = 0; k < 4; k++) begin
         upd(8'h3A, 1'b1);
         rd_chk($sformatf("up_sat_%0d", k), 8'h3A, up_exp[k]);
      end

      // Lower saturation then one increment.
      for (int k = 0; k < 4; k++) begin
         upd(8'h50, (k == 3));
         rd_chk($sformatf("dn_sat_%0d", k), 8'h50, dn_exp[k]);
      end

      // Bypass: same-cycle read sees old, next-cycle read sees new.
      upd_en    = 1'b1;
      upd_addr  = 8'h10;
      upd_taken = 1'b1;
      rd_en     = 1'b1;
      rd_addr   = 8'h10;
      step();
      upd_en    = 1'b0;
      chk("bypass_same_cycle", rd_data, 1);
      step();
      rd_en     = 1'b0;
      chk("bypass_next_cycle", rd_data, 2);
      step();
      rd_chk("bypass_array", 8'h10, 2'd2);

      // Back-to-back updates to one index with reads every cycle.
      rd_en   = 1'b1;
      rd_addr = 8'h05;
      for (int k = 0; k < 6; k++) begin
         upd_en    = (k >= 1 && k <= 3);
         upd_addr  = 8'h05;
         upd_taken = 1'b1;
         step();
         chk($sformatf("collide_%0d", k), {rd_valid, rd_data}, {1'b1, col_exp[k]});
      end
      rd_en  = 1'b0;
      upd_en = 1'b0;

      // Independent read and update in one cycle.
      upd_en    = 1'b1;
      upd_addr  = 8'h60;
      upd_taken = 1'b0;
      rd_en     = 1'b1;
      rd_addr   = 8'h61;
      step();
      upd_en    = 1'b0;
      rd_en     = 1'b0;
      chk("indep_read", rd_data, 1);
      rd_chk("indep_update", 8'h60, 2'd0);

      // Update accepted, then reset while it sits in stage 2.
      upd(8'h77, 1'b1);
      rst_n = 1'b0;
      step();
      chk("rst2_init_done", init_done, 0);
      chk("rst2_rd_data", rd_data, 0);
      rst_n = 1'b1;
      for (int k = 0; k < 100; k++) step();
      chk("mid_sweep_busy", init_done, 0);

      // Reset mid-sweep: a full-length sweep must follow.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      wait_init(edges);
      chk("restart_sweep_length", edges, 256);

      rd_chk("post_rst_3a", 8'h3A, 2'd1);
      rd_chk("post_rst_77", 8'h77, 2'd1);
      rd_chk("post_rst_05", 8'h05, 2'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
